mem_port_arbiter: RTL and testbench

Shares one external memory port between the core's instruction-fetch port (mem_i_*) and data port (mem_d_*). Arbitrates requests round-robin, locks the grant until the request is accepted, and records each accepted request's source and tag in an in-order tracking FIFO. Uses that FIFO to route responses back. Sits between the core and a single-ported TCM/bus bridge in the core testbench and the SoC top.

---
 rtl/mem_arb_pkg.sv | 22 ++
 rtl/mem_arb_fifo.sv | 46 ++++
 rtl/mem_port_arbiter.sv | 143 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the fetch/data memory port arbiter: grant states, source ids
// and the tracking FIFO entry layout.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE,
      ARB_LOCK_I,
      ARB_LOCK_D
   } arb_state_e;

   localparam logic SRC_I = 1'b0;
   localparam logic SRC_D = 1'b1;

   // Widest data-side tag the tracking FIFO stores; narrower TAG_W values are zero-extended.
   localparam int ARB_TAG_W = 11;

   typedef struct packed {
      logic                 src;
      logic [ARB_TAG_W-1:0] tag;
   } fifo_entry_t;

endpackage

// File: rtl/mem_arb_fifo.sv
// Synchronous FIFO with wrap-bit pointers; a push on a full FIFO is taken only
// when a pop happens in the same cycle.
module mem_arb_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 12
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic [WIDTH-1:0]         wdata_i,
   output logic [WIDTH-1:0]         rdata_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]       wr_ptr_q, rd_ptr_q;
   logic [WIDTH-1:0]  mem_q [DEPTH];
   logic              do_push, do_pop;

   assign count_o = wr_ptr_q - rd_ptr_q;
   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (count_o == (AW+1)'(DEPTH));
   assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

   assign do_pop  = pop_i & ~empty_o;
   assign do_push = push_i & (~full_o | do_pop);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between fetch and data ports;
// responses are routed back in order using a {src, tag} tracking FIFO.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int OUTSTANDING = 4,
   parameter int TAG_W       = 11
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mem_i_rd,
   input  logic [31:0]       mem_i_pc,
   output logic              mem_i_accept,
   output logic              mem_i_valid,
   output logic              mem_i_error,
   output logic [31:0]       mem_i_inst,
   input  logic              mem_d_rd,
   input  logic [3:0]        mem_d_wr,
   input  logic [31:0]       mem_d_addr,
   input  logic [31:0]       mem_d_data_wr,
   input  logic [TAG_W-1:0]  mem_d_req_tag,
   output logic              mem_d_accept,
   output logic              mem_d_ack,
   output logic              mem_d_error,
   output logic [31:0]       mem_d_data_rd,
   output logic [TAG_W-1:0]  mem_d_resp_tag,
   output logic              ext_rd,
   output logic [3:0]        ext_wr,
   output logic [31:0]       ext_addr,
   output logic [31:0]       ext_data_wr,
   input  logic              ext_accept,
   input  logic              ext_ack,
   input  logic              ext_error,
   input  logic [31:0]       ext_data_rd,
   output logic              busy,
   output logic              proto_err
);

   localparam int CNT_W = $clog2(OUTSTANDING) + 1;

   arb_state_e   state_q;
   logic         prio_d_q;
   logic         proto_err_q;
   logic         i_req, d_req, gnt_i, gnt_d;
   logic         fifo_full, fifo_empty, push, pop, slot_ok, ext_req_vld, rsp;
   logic [CNT_W-1:0] fifo_count;
   fifo_entry_t  push_entry, head;

   assign i_req = mem_i_rd;
   assign d_req = mem_d_rd | (mem_d_wr != 4'b0);

   always_comb begin
      gnt_i = 1'b0;
      gnt_d = 1'b0;
      unique case (state_q)
         ARB_LOCK_I: gnt_i = 1'b1;
         ARB_LOCK_D: gnt_d = 1'b1;
         default: begin
            if (i_req && d_req) begin
               gnt_d = prio_d_q;
               gnt_i = ~prio_d_q;
            end else begin
               gnt_i = i_req;
               gnt_d = d_req;
            end
         end
      endcase
   end

   // A full FIFO only takes a new request when the head is retired this cycle.
   assign pop     = ext_ack & ~fifo_empty;
   assign slot_ok = ~fifo_full | pop;

   assign ext_rd      = ~rst & slot_ok & ((gnt_i & mem_i_rd) | (gnt_d & mem_d_rd));
   assign ext_wr      = (~rst & slot_ok & gnt_d) ? mem_d_wr : 4'b0;
   assign ext_addr    = rst ? 32'b0 : gnt_i ? mem_i_pc : gnt_d ? mem_d_addr : 32'b0;
   assign ext_data_wr = (~rst & gnt_d) ? mem_d_data_wr : 32'b0;
   assign ext_req_vld = ext_rd | (ext_wr != 4'b0);

   assign mem_i_accept = gnt_i & ext_accept & ext_req_vld;
   assign mem_d_accept = gnt_d & ext_accept & ext_req_vld;
   assign push         = mem_i_accept | mem_d_accept;

   assign push_entry.src = gnt_d ? SRC_D : SRC_I;
   assign push_entry.tag = gnt_d ? ARB_TAG_W'(mem_d_req_tag) : '0;

   mem_arb_fifo #(
      .DEPTH (OUTSTANDING),
      .WIDTH ($bits(fifo_entry_t))
   ) u_track_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push),
      .pop_i   (pop),
      .wdata_i (push_entry),
      .rdata_o (head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   assign rsp            = pop & ~rst;
   assign mem_i_valid    = rsp & (head.src == SRC_I);
   assign mem_i_inst     = mem_i_valid ? ext_data_rd : 32'b0;
   assign mem_i_error    = mem_i_valid & ext_error;
   assign mem_d_ack      = rsp & (head.src == SRC_D);
   assign mem_d_data_rd  = mem_d_ack ? ext_data_rd : 32'b0;
   assign mem_d_error    = mem_d_ack & ext_error;
   assign mem_d_resp_tag = mem_d_ack ? TAG_W'(head.tag) : '0;

   assign busy      = (fifo_count != '0);
   assign proto_err = proto_err_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ARB_IDLE;
         prio_d_q    <= 1'b1;
         proto_err_q <= 1'b0;
      end else begin
         if (ext_ack && fifo_empty) proto_err_q <= 1'b1;
         unique case (state_q)
            ARB_LOCK_I: begin
               if (mem_i_accept) begin
                  state_q  <= ARB_IDLE;
                  prio_d_q <= 1'b1;
               end
            end
            ARB_LOCK_D: begin
               if (mem_d_accept) begin
                  state_q  <= ARB_IDLE;
                  prio_d_q <= 1'b0;
               end
            end
            default: begin
               if (mem_i_accept)      prio_d_q <= 1'b1;
               else if (mem_d_accept) prio_d_q <= 1'b0;
               else if (ext_req_vld)  state_q  <= gnt_d ? ARB_LOCK_D : ARB_LOCK_I;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a vector table for the basic flow plus
// hand-written lock, full-FIFO and reset/protocol sequences.
module tb_mem_port_arbiter;

   logic        clk, rst;
   logic        mem_i_rd;
   logic [31:0] mem_i_pc;
   logic        mem_i_accept, mem_i_valid, mem_i_error;
   logic [31:0] mem_i_inst;
   logic        mem_d_rd;
   logic [3:0]  mem_d_wr;
   logic [31:0] mem_d_addr, mem_d_data_wr;
   logic [10:0] mem_d_req_tag;
   logic        mem_d_accept, mem_d_ack, mem_d_error;
   logic [31:0] mem_d_data_rd;
   logic [10:0] mem_d_resp_tag;
   logic        ext_rd;
   logic [3:0]  ext_wr;
   logic [31:0] ext_addr, ext_data_wr;
   logic        ext_accept, ext_ack, ext_error;
   logic [31:0] ext_data_rd;
   logic        busy, proto_err;

   int checks = 0;
   int errors = 0;

   mem_port_arbiter #(.OUTSTANDING(4), .TAG_W(11)) dut (
      .clk(clk), .rst(rst),
      .mem_i_rd(mem_i_rd), .mem_i_pc(mem_i_pc), .mem_i_accept(mem_i_accept),
      .mem_i_valid(mem_i_valid), .mem_i_error(mem_i_error), .mem_i_inst(mem_i_inst),
      .mem_d_rd(mem_d_rd), .mem_d_wr(mem_d_wr), .mem_d_addr(mem_d_addr),
      .mem_d_data_wr(mem_d_data_wr), .mem_d_req_tag(mem_d_req_tag),
      .mem_d_accept(mem_d_accept), .mem_d_ack(mem_d_ack), .mem_d_error(mem_d_error),
      .mem_d_data_rd(mem_d_data_rd), .mem_d_resp_tag(mem_d_resp_tag),
      .ext_rd(ext_rd), .ext_wr(ext_wr), .ext_addr(ext_addr), .ext_data_wr(ext_data_wr),
      .ext_accept(ext_accept), .ext_ack(ext_ack), .ext_error(ext_error),
      .ext_data_rd(ext_data_rd), .busy(busy), .proto_err(proto_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic        i_rd;
      logic [31:0] pc;
      logic        d_rd;
      logic [3:0]  d_wr;
      logic [31:0] d_addr;
      logic [31:0] d_wdata;
      logic [10:0] d_tag;
      logic        acc;
      logic        ack;
      logic        err;
      logic [31:0] data;
   } in_t;

   typedef struct packed {
      logic        ext_rd;
      logic [3:0]  ext_wr;
      logic [31:0] ext_addr;
      logic [31:0] ext_dw;
      logic        i_acc;
      logic        d_acc;
      logic        i_vld;
      logic        i_err;
      logic [31:0] i_inst;
      logic        d_ack;
      logic        d_err;
      logic [31:0] d_data;
      logic [10:0] d_tag;
      logic        busy;
      logic        perr;
   } out_t;

   typedef struct {
      string name;
      in_t   vin;
      out_t  vexp;
   } vec_t;

   function automatic in_t mk_in(logic ir, logic [31:0] pc, logic dr, logic [3:0] dw,
                                 logic [31:0] da, logic [31:0] dd, logic [10:0] dt,
                                 logic acc, logic ack, logic err, logic [31:0] data);
      in_t v;
      v.i_rd = ir; v.pc = pc; v.d_rd = dr; v.d_wr = dw; v.d_addr = da; v.d_wdata = dd;
      v.d_tag = dt; v.acc = acc; v.ack = ack; v.err = err; v.data = data;
      return v;
   endfunction

   function automatic out_t mk_out(logic erd, logic [3:0] ewr, logic [31:0] ea, logic [31:0] edw,
                                   logic ia, logic da, logic iv, logic ie, logic [31:0] ii,
                                   logic dk, logic de, logic [31:0] dd, logic [10:0] dt,
                                   logic bs, logic pe);
      out_t o;
      o.ext_rd = erd; o.ext_wr = ewr; o.ext_addr = ea; o.ext_dw = edw;
      o.i_acc = ia; o.d_acc = da; o.i_vld = iv; o.i_err = ie; o.i_inst = ii;
      o.d_ack = dk; o.d_err = de; o.d_data = dd; o.d_tag = dt; o.busy = bs; o.perr = pe;
      return o;
   endfunction

   task automatic apply(input in_t v);
      mem_i_rd = v.i_rd; mem_i_pc = v.pc; mem_d_rd = v.d_rd; mem_d_wr = v.d_wr;
      mem_d_addr = v.d_addr; mem_d_data_wr = v.d_wdata; mem_d_req_tag = v.d_tag;
      ext_accept = v.acc; ext_ack = v.ack; ext_error = v.err; ext_data_rd = v.data;
   endtask

   // full=1 also demands zero address/write-data when no request is presented.
   task automatic check(input string nm, input out_t exp_in, input bit full);
      out_t a, e;
      e = exp_in;
      a = mk_out(ext_rd, ext_wr, ext_addr, ext_data_wr, mem_i_accept, mem_d_accept,
                 mem_i_valid, mem_i_error, mem_i_inst, mem_d_ack, mem_d_error,
                 mem_d_data_rd, mem_d_resp_tag, busy, proto_err);
      if (!e.i_vld) begin a.i_inst = '0; e.i_inst = '0; end
      if (!e.d_ack) begin a.d_data = '0; e.d_data = '0; a.d_tag = '0; e.d_tag = '0; end
      if (!full && !e.ext_rd && e.ext_wr == 4'b0) begin
         a.ext_addr = '0; e.ext_addr = '0; a.ext_dw = '0; e.ext_dw = '0;
      end
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, a, e);
      end
   endtask

   task automatic step(input string nm, input in_t vi, input out_t vo, input bit full);
      apply(vi);
      @(negedge clk);
      check(nm, vo, full);
      @(posedge clk);
      #1;
   endtask

   localparam in_t  IN0  = '0;
   localparam out_t OUT0 = '0;

   vec_t vecs[11];

   initial begin
      vecs[0]  = '{"idle",      IN0, OUT0};
      vecs[1]  = '{"fetch_acc", mk_in(1,32'h100,0,0,0,0,0,1,0,0,0),
                   mk_out(1,0,32'h100,0,1,0,0,0,0,0,0,0,0,0,0)};
      vecs[2]  = '{"fetch_wait", IN0, mk_out(0,0,0,0,0,0,0,0,0,0,0,0,0,1,0)};
      vecs[3]  = '{"fetch_resp", mk_in(0,0,0,0,0,0,0,0,1,0,32'h13),
                   mk_out(0,0,0,0,0,0,1,0,32'h13,0,0,0,0,1,0)};
      vecs[4]  = '{"cont_d",    mk_in(1,32'h200,1,0,32'h300,0,11'h2A,1,0,0,0),
                   mk_out(1,0,32'h300,0,0,1,0,0,0,0,0,0,0,0,0)};
      vecs[5]  = '{"cont_i",    mk_in(1,32'h200,1,0,32'h300,0,11'h2A,1,0,0,0),
                   mk_out(1,0,32'h200,0,1,0,0,0,0,0,0,0,0,1,0)};
      vecs[6]  = '{"wr_d",      mk_in(0,0,0,4'hF,32'h400,32'hDEADBEEF,11'h155,1,0,0,0),
                   mk_out(0,4'hF,32'h400,32'hDEADBEEF,0,1,0,0,0,0,0,0,0,1,0)};
      vecs[7]  = '{"rsp_d2a",   mk_in(0,0,0,0,0,0,0,0,1,0,32'hAAAA0001),
                   mk_out(0,0,0,0,0,0,0,0,0,1,0,32'hAAAA0001,11'h2A,1,0)};
      vecs[8]  = '{"rsp_i_err", mk_in(0,0,0,0,0,0,0,0,1,1,32'h12345678),
                   mk_out(0,0,0,0,0,0,1,1,32'h12345678,0,0,0,0,1,0)};
      vecs[9]  = '{"rsp_d155",  mk_in(0,0,0,0,0,0,0,0,1,0,32'h0),
                   mk_out(0,0,0,0,0,0,0,0,0,1,0,32'h0,11'h155,1,0)};
      vecs[10] = '{"drained",   IN0, OUT0};

      rst = 1'b1;
      apply(IN0);
      @(negedge clk);
      check("reset_state", OUT0, 1'b1);
      @(posedge clk);
      #1 rst = 1'b0;

      for (int k = 0; k < 11; k++) step(vecs[k].name, vecs[k].vin, vecs[k].vexp, 1'b0);

      // Lock: D presented but not accepted, I requests meanwhile; priority is now I.
      step("lock_d0", mk_in(0,0,1,0,32'h500,0,11'h7,0,0,0,0),
           mk_out(1,0,32'h500,0,0,0,0,0,0,0,0,0,0,0,0), 1'b0);
      for (int k = 1; k < 5; k++)
         step($sformatf("lock_hold%0d", k), mk_in(1,32'h600,1,0,32'h500,0,11'h7,0,0,0,0),
              mk_out(1,0,32'h500,0,0,0,0,0,0,0,0,0,0,0,0), 1'b0);
      step("lock_d_acc", mk_in(1,32'h600,1,0,32'h500,0,11'h7,1,0,0,0),
           mk_out(1,0,32'h500,0,0,1,0,0,0,0,0,0,0,0,0), 1'b0);
      step("lock_i_acc", mk_in(1,32'h600,0,0,0,0,0,1,0,0,0),
           mk_out(1,0,32'h600,0,1,0,0,0,0,0,0,0,0,1,0), 1'b0);
      step("lock_rsp_d", mk_in(0,0,0,0,0,0,0,0,1,0,32'h77),
           mk_out(0,0,0,0,0,0,0,0,0,1,0,32'h77,11'h7,1,0), 1'b0);
      step("lock_rsp_i", mk_in(0,0,0,0,0,0,0,0,1,0,32'h88),
           mk_out(0,0,0,0,0,0,1,0,32'h88,0,0,0,0,1,0), 1'b0);

      // Full FIFO: four accepts with no acks.
      for (int k = 0; k < 4; k++)
         step($sformatf("fill%0d", k),
              mk_in(0,0,1,0,32'h800 + 32'(4*k),0,11'(k+1),1,0,0,0),
              mk_out(1,0,32'h800 + 32'(4*k),0,0,1,0,0,0,0,0,0,0,(k != 0),0), 1'b0);
      step("full_block", mk_in(0,0,1,0,32'h900,0,11'h5,1,0,0,0),
           mk_out(0,0,0,0,0,0,0,0,0,0,0,0,0,1,0), 1'b0);
      step("full_pushpop", mk_in(0,0,1,0,32'h900,0,11'h5,1,1,0,32'hF1),
           mk_out(1,0,32'h900,0,0,1,0,0,0,1,0,32'hF1,11'h1,1,0), 1'b0);
      step("full_still", mk_in(0,0,1,0,32'hA00,0,11'h6,1,0,0,0),
           mk_out(0,0,0,0,0,0,0,0,0,0,0,0,0,1,0), 1'b0);
      for (int k = 0; k < 4; k++)
         step($sformatf("drain%0d", k), mk_in(0,0,0,0,0,0,0,0,1,0,32'hF2 + 32'(k)),
              mk_out(0,0,0,0,0,0,0,0,0,1,0,32'hF2 + 32'(k),11'(k+2),1,0), 1'b0);
      step("full_empty", IN0, OUT0, 1'b0);

      // Reset with two entries outstanding, then a stray ack.
      step("rst_pre_i", mk_in(1,32'hC00,0,0,0,0,0,1,0,0,0),
           mk_out(1,0,32'hC00,0,1,0,0,0,0,0,0,0,0,0,0), 1'b0);
      step("rst_pre_d", mk_in(0,0,1,0,32'hD00,0,11'h9,1,0,0,0),
           mk_out(1,0,32'hD00,0,0,1,0,0,0,0,0,0,0,1,0), 1'b0);
      rst = 1'b1;
      step("rst_outputs", mk_in(1,32'hC04,1,4'h3,32'hD04,32'h1234,11'h9,1,1,1,32'h99),
           OUT0, 1'b1);
      rst = 1'b0;
      step("post_rst_ack", mk_in(0,0,0,0,0,0,0,0,1,0,32'h55), OUT0, 1'b0);
      step("proto_set", IN0, mk_out(0,0,0,0,0,0,0,0,0,0,0,0,0,0,1), 1'b0);
      step("proto_sticky", IN0, mk_out(0,0,0,0,0,0,0,0,0,0,0,0,0,0,1), 1'b0);
      rst = 1'b1;
      step("proto_rst", IN0, OUT0, 1'b1);
      rst = 1'b0;
      step("proto_clear", IN0, OUT0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
